// File: rtl/ua_switch_arbiter.sv
// ua_switch_arbiter
// Time-shares the analog pin bank ua[5:0] between NREQ on-die requesters.
// A round-robin winner gets its pass switches closed (MAKE), is granted after
// SETTLE cycles (GRANT), and every hand-over goes through DEAD cycles with all
// switches open (BREAK), so two structures never share a pin.
// Optional build macro: ARB_TIMEOUT_EN - revoke a grant after MAX_HOLD cycles
// and pulse timeout; without it grants persist and timeout is tied low.
module ua_switch_arbiter #(
    parameter int NREQ     = 4,
    parameter int SETTLE   = 2,
    parameter int DEAD     = 3,
    parameter int MAX_HOLD = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_idx,
    input  logic [5:0]      cfg_mask,
    output logic [NREQ-1:0] gnt,
    output logic [5:0]      sw_en,
    output logic            busy,
    output logic            timeout
);

    localparam int IW   = $clog2(NREQ);
    localparam int CMAX = (SETTLE > DEAD) ? SETTLE : DEAD;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]   CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]   CNT_SETTLE = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_DEAD   = CW'(DEAD - 1);
    localparam logic [NREQ-1:0] GNT_ONE    = NREQ'(1);
    localparam logic [IW-1:0]   RR_RESET   = IW'(NREQ - 1);

`ifdef ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
`endif

    // Reject parameter sets the sequencing cannot honour.
    if (NREQ < 2 || NREQ > 8 || SETTLE < 1 || DEAD < 1 || MAX_HOLD < 1) begin : g_bad_param
        $error("ua_switch_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAKE  = 2'd1,
        S_GRANT = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [5:0]      r_sw_en;
    logic [5:0]      r_mask [NREQ];
`ifdef ARB_TIMEOUT_EN
    logic [HW-1:0]   r_hold;
    logic            r_timeout;
`endif

    logic [IW-1:0]   w_cand;
    logic [IW-1:0]   w_winner;
    logic            w_found;
    logic [IW-1:0]   w_cfg_idx;
    logic            w_cfg_ok;
    logic            w_unused_cfg_idx;

    // Only the low clog2(NREQ) index bits address a mask; the rest are ignored.
    assign w_cfg_idx        = cfg_idx[IW-1:0];
    assign w_cfg_ok         = (int'(w_cfg_idx) < NREQ);
    assign w_unused_cfg_idx = ^cfg_idx;

    // Round-robin search: first requester at or after rr+1, wrapping modulo NREQ.
    always_comb begin
        w_cand   = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_rr) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Pin-mask table; writes land in any state and reads see the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_mask[i] <= 6'h00;
            end
        end else if (cfg_we && w_cfg_ok) begin
            r_mask[w_cfg_idx] <= cfg_mask;
        end
    end

    // Ownership sequencer: IDLE -> MAKE (settle) -> GRANT -> BREAK (dead time).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_rr      <= RR_RESET;
            r_cnt     <= CNT_ZERO;
            r_gnt     <= '0;
            r_sw_en   <= 6'h00;
`ifdef ARB_TIMEOUT_EN
            r_hold    <= HOLD_ZERO;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // Switch pattern is frozen here for the whole ownership.
                        r_owner <= w_winner;
                        r_rr    <= w_winner;
                        r_sw_en <= r_mask[w_winner];
                        r_cnt   <= CNT_SETTLE;
                        r_state <= S_MAKE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MAKE: begin
                    if (!req[r_owner]) begin
                        // Requester gave up while settling: open and run dead time.
                        r_sw_en <= 6'h00;
                        r_cnt   <= CNT_DEAD;
                        r_state <= S_BREAK;
                    end else if (r_cnt == CNT_ZERO) begin
                        r_gnt   <= GNT_ONE << r_owner;
`ifdef ARB_TIMEOUT_EN
                        r_hold  <= HOLD_ZERO;
`endif
                        r_state <= S_GRANT;
                    end else begin
                        r_cnt   <= r_cnt - CNT_ONE;
                    end
                end
                S_GRANT: begin
                    if (!req[r_owner]) begin
                        r_gnt   <= '0;
                        r_sw_en <= 6'h00;
                        r_cnt   <= CNT_DEAD;
                        r_state <= S_BREAK;
`ifdef ARB_TIMEOUT_EN
                    end else if (r_hold == HOLD_LAST) begin
                        // Owner overstayed: revoke exactly like a release and flag it.
                        // r_rr already holds this owner, so the others go first.
                        r_gnt     <= '0;
                        r_sw_en   <= 6'h00;
                        r_cnt     <= CNT_DEAD;
                        r_state   <= S_BREAK;
                        r_timeout <= 1'b1;
                    end else begin
                        r_hold  <= r_hold + HOLD_ONE;
                    end
`else
                    end else begin
                        r_state <= S_GRANT;
                    end
`endif
                end
                S_BREAK: begin
                    r_gnt   <= '0;
                    r_sw_en <= 6'h00;
                    if (r_cnt == CNT_ZERO) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_sw_en <= 6'h00;
                    r_cnt   <= CNT_ZERO;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign sw_en = r_sw_en;
    assign busy  = (r_state != S_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/ua_switch_arbiter.md
Name: ua_switch_arbiter

Overview:
- Time-shares the analog pin bank ua[5:0] between NREQ on-die analog requesters, such as test structures or measurement paths.
- Each requester has a programmable 6-bit pin mask.
- The arbiter picks one requester round-robin and closes that requester's analog pass switches.
- It waits a settle time before granting, and enforces break-before-make dead time between owners, so two structures never share a pin.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SETTLE, 2, cycles between switch close and gnt assertion (>=1).
- DEAD, 3, cycles of all-switches-open between owners (>=1).
- MAX_HOLD, 255, grant cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request level.
- cfg_we  in  1  mask write strobe.
- cfg_idx  in  3  requester index for the mask write; bits above clog2(NREQ) are ignored.
- cfg_mask  in  6  pin mask written to mask[cfg_idx].
- gnt  out  NREQ  one-hot grant, registered.
- sw_en  out  6  analog switch enables for ua[5:0], registered.
- busy  out  1  high whenever state != IDLE.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset values: gnt=0, sw_en=0, busy=0, timeout=0, state=IDLE, all mask[i]=6'h00, rr pointer=NREQ-1 (so req[0] is favoured first).
- Mask writes: on every clock with cfg_we=1, mask[cfg_idx] <= cfg_mask.
  - Writes are accepted in any state.
  - sw_en for the current grant is latched at MAKE entry; a later write to that mask has no effect until the next grant.
- Winner selection: the lowest index at or after rr+1, modulo NREQ, with req set. This is computed combinationally and sampled in IDLE.
- IDLE: if req != 0, then on the clock edge (E0): owner <= winner, rr <= winner, sw_en <= mask[winner], cnt <= SETTLE-1, state <= MAKE.
- MAKE:
  - If req[owner]=0: sw_en <= 0, cnt <= DEAD-1, state <= BREAK (abort; gnt never asserted).
  - Else if cnt=0: gnt <= onehot(owner), hold <= 0, state <= GRANT.
  - Else cnt <= cnt-1.
  - Net effect: gnt rises at edge E0+SETTLE.
- GRANT:
  - If req[owner]=0: gnt <= 0, sw_en <= 0 on the same edge, cnt <= DEAD-1, state <= BREAK.
  - Other requesters' req changes are ignored.
- BREAK: sw_en=0, gnt=0. Count down cnt; when cnt=0, state <= IDLE. IDLE lasts at least one cycle before the next MAKE.
- Latency:
  - req drop sampled at edge G gives gnt/sw_en low after G.
  - Earliest next sw_en is after edge G+DEAD+1.
- Zero mask: a requester with mask 0 is still arbitrated and granted normally, with sw_en=0.
- Invariants:
  - At most one gnt bit is set.
  - gnt!=0 implies state=GRANT.
  - sw_en!=0 only in MAKE or GRANT.
- Reset mid-operation: the next edge with rst=1 forces all reset values. Switches open immediately, with no dead-time sequence.
- Simultaneous events: a cfg write and a req change on the same edge both take effect. The sw_en latch uses the pre-write mask value.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, hold increments each cycle.
  - When hold = MAX_HOLD-1 and req[owner] is still 1, the edge performs the normal GRANT->BREAK transition and sets timeout=1 for exactly one cycle.
  - The timed-out owner becomes rr, so the others get priority. It is re-eligible afterwards if still requesting.
- Undefined: hold counter is absent, grants persist indefinitely, timeout is tied 0.

Test Plan:
- Reset then grant timing (defaults): mask[1]=6'h05, then req=4'b0010 → sw_en=6'h05 one cycle later; gnt=4'b0010 SETTLE=2 cycles after sw_en; busy=1.
- Round-robin: req=4'b1111 held, each owner releases 1 cycle after grant → grant order 0,1,2,3,0. Between each pair: 3 cycles with sw_en=0 and gnt=0 (DEAD), then ≥1 IDLE cycle.
- Abort in MAKE: req[2] pulsed for 1 cycle → sw_en=mask[2] for 1 cycle, gnt stays 0, BREAK of 3 cycles, back to IDLE.
- Mask write during grant: owner 0 granted with mask 6'h3F, write mask[0]=6'h01 → sw_en stays 6'h3F. After release and re-request, sw_en=6'h01.
- Reset mid-GRANT: assert rst for 1 cycle while gnt=4'b0100 → gnt=0, sw_en=0, busy=0, masks=0 after that edge. The next req[0] wins first.
- ARB_TIMEOUT_EN, MAX_HOLD=8: req=4'b0011 held → gnt[0] high exactly 8 cycles, then a 1-cycle timeout pulse, then gnt[1] is granted next.
